// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/mask types and the memory arbiter state encoding
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;
endpackage

// File: rtl/arb_req_latch.sv
// arb_req_latch: holds the granted request so physical memory sees stable values while busy
module arb_req_latch
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  lc3b_word      addr,
  input  lc3b_word      wdata,
  input  lc3b_mem_wmask be,
  input  logic          write,
  output lc3b_word      lat_addr,
  output lc3b_word      lat_wdata,
  output lc3b_mem_wmask lat_be,
  output logic          lat_write
);
  // capture on grant, clear asynchronously on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {lat_addr, lat_wdata, lat_be, lat_write} <= '0;
    else if (load) {lat_addr, lat_wdata, lat_be, lat_write} <= {addr, wdata, be, write};
endmodule

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one physical memory port between fetch and MEM stages with D priority and I anti-starvation
module pipe_mem_arbiter
  import lc3b_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_read,
  input  lc3b_word      i_address,
  output lc3b_word      i_rdata,
  output logic          i_resp,
  input  logic          d_read,
  input  logic          d_write,
  input  lc3b_word      d_address,
  input  lc3b_word      d_wdata,
  input  lc3b_mem_wmask d_byte_enable,
  output lc3b_word      d_rdata,
  output logic          d_resp,
  output logic          pmem_read,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_word      pmem_wdata,
  output lc3b_mem_wmask pmem_byte_enable,
  input  lc3b_word      pmem_rdata,
  input  logic          pmem_resp
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  arb_state_t state;
  logic [CW-1:0] starve_cnt;
  logic idle, i_busy, d_busy, grant_d, grant_i, lat_write;
  lc3b_word lat_addr, lat_wdata;
  lc3b_mem_wmask lat_be;
  assign idle = state == IDLE;
  assign i_busy = state == I_BUSY;
  assign d_busy = state == D_BUSY;
  assign grant_d = idle && (d_read || d_write) && (!i_read || starve_cnt < LIM);
  assign grant_i = idle && i_read && !grant_d;
  arb_req_latch u_latch (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (grant_d || grant_i),
    .addr      (grant_d ? d_address : i_address),
    .wdata     (grant_d ? d_wdata : '0),
    .be        (grant_d ? d_byte_enable : 2'b11),
    .write     (grant_d && d_write),
    .lat_addr  (lat_addr),
    .lat_wdata (lat_wdata),
    .lat_be    (lat_be),
    .lat_write (lat_write)
  );
  // grant only from IDLE; any completion returns to IDLE, forcing a turnaround cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else if (!idle && pmem_resp) state <= IDLE;
    else if (grant_d) state <= D_BUSY;
    else if (grant_i) state <= I_BUSY;
  // count D grants taken over a waiting fetch; a D grant with i_read high implies count < limit, so it saturates
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_cnt <= '0;
    else if (grant_i) starve_cnt <= '0;
    else if (grant_d && i_read) starve_cnt <= starve_cnt + CW'(1);
  assign pmem_read = i_busy || (d_busy && !lat_write);
  assign pmem_write = d_busy && lat_write;
  assign pmem_address = (i_busy || d_busy) ? lat_addr : '0;
  assign pmem_wdata = d_busy ? lat_wdata : '0;
  assign pmem_byte_enable = (i_busy || d_busy) ? lat_be : '0;
  assign i_resp = i_busy && pmem_resp;
  assign d_resp = d_busy && pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: randomized scoreboard bench with a transaction-level arbiter model and memory responder
module tb_pipe_mem_arbiter;
  localparam int LIMIT = 4;
  typedef struct packed {
    logic        d;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
  } txn_t;
  typedef struct packed {
    logic        d;
    logic [15:0] rdata;
  } rsp_t;
  logic clk = 0, rst_n = 0;
  logic i_read = 0, d_read = 0, d_write = 0;
  logic [15:0] i_address = 0, d_address = 0, d_wdata = 0;
  logic [1:0] d_byte_enable = 0;
  logic [15:0] i_rdata, d_rdata, pmem_address, pmem_wdata;
  logic i_resp, d_resp, pmem_read, pmem_write;
  logic [1:0] pmem_byte_enable;
  logic [15:0] pmem_rdata = 0;
  logic pmem_resp = 0;
  txn_t exp_q[$];
  rsp_t resp_q[$];
  txn_t cur;
  logic act = 0;
  byte obs[$];
  int n_resp = 0, checks = 0, passes = 0;
  int fix_lat = -1;
  logic fix_rd_en = 0, late_resp = 0;
  logic [15:0] fix_rd = 0;
  logic m_busy = 0, m_d = 0;
  int m_cnt = 0, m_age = 0, m_lat = 0;

  pipe_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // reference model: one transaction at a time, D first unless the fetch has waited LIMIT D grants
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_cnt = 0;
      exp_q.delete();
    end else if (m_busy) begin
      if (pmem_resp) m_busy = 0;
      else m_age++;
    end else if ((d_read || d_write) && (!i_read || m_cnt < LIMIT)) begin
      exp_q.push_back('{1'b1, d_write, d_address, d_write ? d_wdata : 16'h0, d_byte_enable});
      if (i_read) m_cnt++;
      m_busy = 1; m_d = 1; m_age = 0;
      m_lat = fix_lat >= 0 ? fix_lat : $urandom_range(0, 3);
    end else if (i_read) begin
      exp_q.push_back('{1'b0, 1'b0, i_address, 16'h0, 2'b11});
      m_cnt = 0;
      m_busy = 1; m_d = 0; m_age = 0;
      m_lat = fix_lat >= 0 ? fix_lat : $urandom_range(0, 3);
    end
  end

  // physical memory: completes the model's transaction after its chosen latency
  always @(negedge clk) begin
    pmem_rdata = fix_rd_en ? fix_rd : 16'($urandom);
    if (rst_n && m_busy && m_age == m_lat) begin
      pmem_resp = 1;
      resp_q.push_back('{m_d, pmem_rdata});
    end else pmem_resp = late_resp;
  end

  // monitor: pops expected requests/responses as the DUT presents them
  always @(negedge clk) begin
    txn_t t;
    rsp_t r;
    #2;
    if (!rst_n) begin
      act = 0;
      resp_q.delete();
      chk("reset_outputs", {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable, i_resp, d_resp}, 64'h0);
    end else begin
      if (pmem_read || pmem_write) begin
        if (!act) begin
          if (exp_q.size() == 0) chk("spurious_request", {pmem_read, pmem_write}, 64'h0);
          else begin
            cur = exp_q.pop_front();
            act = 1;
          end
        end
        if (act)
          chk("pmem_request", {pmem_write, pmem_read, pmem_address, cur.wr ? pmem_wdata : 16'h0, pmem_byte_enable},
              {cur.wr, !cur.wr, cur.addr, cur.wdata, cur.be});
      end else if (act || exp_q.size() > 0) begin
        t = act ? cur : exp_q[0];
        chk("missing_request", {pmem_write, pmem_read}, {t.wr, !t.wr});
      end
      if (resp_q.size() > 0) begin
        r = resp_q.pop_front();
        chk("response", {i_resp, d_resp, r.d ? d_rdata : i_rdata}, {!r.d, r.d, r.rdata});
        if (i_resp || d_resp) obs.push_back(d_resp ? 8'h44 : 8'h49);
        n_resp++;
        act = 0;
      end else chk("no_response", {i_resp, d_resp}, 64'h0);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  task automatic wait_resp(input int k, input string name);
    int t = n_resp + k;
    int lim = 200;
    while (n_resp < t && lim > 0) begin
      cyc();
      lim--;
    end
    chk({name, "_timeout"}, 64'(n_resp >= t), 64'h1);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #4 rst_n = 0;
    #1 chk("async_reset", {pmem_read, pmem_write, i_resp, d_resp}, 64'h0);
    i_read = 0; d_read = 0; d_write = 0;
    @(negedge clk);
    #4 rst_n = 1;
  endtask

  task automatic check_order(input int base, input string s);
    for (int k = 0; k < s.len(); k++)
      chk("grant_order", 64'(obs.size() > base + k ? obs[base + k] : 8'h0), 64'(s[k]));
  endtask

  initial begin
    int base;
    repeat (2) @(negedge clk);
    #4 rst_n = 1;
    cyc();
    i_read = 1; i_address = 16'h0040; fix_lat = 2; fix_rd_en = 1; fix_rd = 16'h1234;
    wait_resp(1, "i_only");
    i_read = 0;
    cyc(2);
    d_write = 1; d_address = 16'h8000; d_wdata = 16'hBEEF; d_byte_enable = 2'b10; fix_rd = 16'h5A5A;
    wait_resp(1, "d_write");
    d_write = 0;
    cyc(2);
    d_read = 1; d_address = 16'h8000; d_byte_enable = 2'b11; fix_lat = 3;
    cyc(2);
    d_address = 16'h9000;
    wait_resp(1, "addr_change");
    d_read = 0;
    cyc(2);
    d_read = 1; d_write = 1; d_address = 16'h0010; d_wdata = 16'hC0DE; fix_lat = 1;
    wait_resp(1, "rd_wr_both");
    d_read = 0; d_write = 0;
    cyc(2);
    fix_lat = -1; fix_rd_en = 0;
    i_read = 1; d_read = 1; i_address = 16'h0100; d_address = 16'h0200;
    base = obs.size();
    wait_resp(6, "contention");
    check_order(base, "DDDDID");
    fix_lat = 8;
    cyc(2);
    fix_lat = -1;
    reset_pulse();
    i_read = 1; d_read = 1;
    base = obs.size();
    wait_resp(5, "contention_after_reset");
    check_order(base, "DDDDI");
    i_read = 0; d_read = 0;
    cyc(8);
    i_read = 1; i_address = 16'h0300; fix_lat = 10;
    cyc(2);
    chk("i_busy_before_reset", {pmem_read, pmem_address}, {1'b1, 16'h0300});
    reset_pulse();
    fix_lat = -1;
    late_resp = 1;
    cyc();
    chk("late_resp_ignored", {i_resp, d_resp, pmem_read, pmem_write}, 64'h0);
    cyc();
    late_resp = 0;
    repeat (3000) begin
      cyc();
      i_read = $urandom_range(0, 2) != 0;
      i_address = 16'($urandom);
      d_read = $urandom_range(0, 2) == 0;
      d_write = $urandom_range(0, 3) == 0;
      d_address = 16'($urandom);
      d_wdata = 16'($urandom);
      d_byte_enable = 2'($urandom);
      if ($urandom_range(0, 499) == 0) reset_pulse();
    end
    i_read = 0; d_read = 0; d_write = 0;
    cyc(8);
    chk("drain", {act, exp_q.size() == 0}, {1'b0, 1'b1});
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
